wave_sequencer: RTL

- Phase-accumulator controller that sequences a waveform lookup table with a 1-cycle registered read. Examples are the triangle, square and saw tables in the synth module.
- On each sample strobe it advances phase by a programmable tuning word, drives the table address, and captures the table output one cycle later.
- It presents the captured sample to the downstream mixer/codec path with a valid/ready handshake.
- Gate input restarts phase for note-on behaviour.

---
 rtl/synth_pkg.sv | 17 +
 rtl/wave_sequencer_phase_accum.sv | 43 ++++
 rtl/wave_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and default widths for the waveform synth blocks.
package synth_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned ADDR_WIDTH  = 8;
  localparam int unsigned PHASE_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } seq_state_t;

  typedef logic [PHASE_WIDTH-1:0] phase_t;

endpackage

// File: rtl/wave_sequencer_phase_accum.sv
// Phase accumulator: holds the tuning word and phase, exposes the table address.
module phase_accum #(
  parameter int unsigned ADDR_WIDTH  = synth_pkg::ADDR_WIDTH,
  parameter int unsigned PHASE_WIDTH = synth_pkg::PHASE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   advance_i,
  input  logic                   gate_i,
  input  logic                   freq_load_i,
  input  logic [PHASE_WIDTH-1:0] freq_word_i,
  output logic [ADDR_WIDTH-1:0]  addr_o
);

  logic [PHASE_WIDTH-1:0] freq_q, freq_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;

  // An advance on the same edge as a load still uses the old tuning word.
  always_comb begin
    freq_d  = freq_q;
    phase_d = phase_q;
    if (freq_load_i) begin
      freq_d = freq_word_i;
    end
    if (advance_i) begin
      phase_d = gate_i ? PHASE_WIDTH'(phase_q + freq_q) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_q  <= '0;
      phase_q <= '0;
    end else begin
      freq_q  <= freq_d;
      phase_q <= phase_d;
    end
  end

  // Phase only moves on an advance, so its top slice is a stable registered address.
  assign addr_o = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: rtl/wave_sequencer.sv
// Sample-rate sequencer: steps a phase accumulator, reads a registered wave
// table and hands captured samples downstream over valid/ready.
module wave_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = synth_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = synth_pkg::ADDR_WIDTH,
  parameter int unsigned PHASE_WIDTH = synth_pkg::PHASE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic [PHASE_WIDTH-1:0] freq_word,
  input  logic                   freq_load,
  input  logic                   gate,
  output logic [ADDR_WIDTH-1:0]  wave_addr,
  input  logic [DATA_WIDTH-1:0]  wave_data,
  output logic [DATA_WIDTH-1:0]  sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun
);

  seq_state_t state_q, state_d;

  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  advance_c;

  assign advance_c = (state_q == IDLE) && (tick || pending_q);

  phase_accum #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_phase_accum (
    .clk         (clk),
    .reset_n     (reset_n),
    .advance_i   (advance_c),
    .gate_i      (gate),
    .freq_load_i (freq_load),
    .freq_word_i (freq_word),
    .addr_o      (wave_addr)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      sample_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      sample_q  <= sample_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (advance_c) state_d = ADDR;
      ADDR:    state_d = WAIT;
      WAIT:    state_d = OUT;
      OUT:     if (sample_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output, pending and overrun logic.
  always_comb begin
    pending_d = pending_q;
    overrun_d = 1'b0;
    valid_d   = valid_q;
    sample_d  = sample_q;

    if (state_q == IDLE) begin
      // A pending tick is consumed; a fresh tick arriving with it stays queued.
      if (advance_c) begin
        pending_d = pending_q && tick;
      end
    end else if (tick) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      WAIT: begin
        sample_d = wave_data;
        valid_d  = 1'b1;
      end
      OUT: begin
        if (sample_ready) begin
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule
